counter_monitor: RTL

- Passive checker on the other end of the 0..10 wrap counter interface. It samples the counter's enable and 8-bit count output and predicts each next value. It flags sequence and range errors, counts wraps and errors, and reports a lock status.
- Sits beside the counter in the demo bench and in-system as a health monitor. It never drives the counter.

---
 rtl/counter_monitor_if.sv | 44 ++++
 rtl/counter_monitor.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/counter_monitor_if.sv
// rtl/counter_monitor_if.sv - observation bus and status outputs of the wrap counter monitor
interface counter_monitor_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    // Observed counter signals
    logic             cnt_en;
    logic [WIDTH-1:0] cnt_in;

    // Monitor status
    logic [WIDTH-1:0] exp_val;
    logic             locked;
    logic             mismatch;
    logic             range_err;
    logic             err_sticky;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] wrap_cnt;

    // Side that owns the counter and reads the health status
    modport master (
        output cnt_en,
        output cnt_in,
        input  exp_val,
        input  locked,
        input  mismatch,
        input  range_err,
        input  err_sticky,
        input  err_cnt,
        input  wrap_cnt
    );

    // The monitor itself: only observes the counter, drives status
    modport slave (
        input  cnt_en,
        input  cnt_in,
        output exp_val,
        output locked,
        output mismatch,
        output range_err,
        output err_sticky,
        output err_cnt,
        output wrap_cnt
    );
endinterface

// File: rtl/counter_monitor.sv
// rtl/counter_monitor.sv - passive checker for the 0..WRAP_VAL wrap counter (optional clr port via COUNTER_MONITOR_CLR_EN)
module counter_monitor #(
    parameter int WIDTH    = 8,
    parameter int WRAP_VAL = 10,
    parameter int LOCK_N   = 3,
    parameter int CNT_W    = 16
) (
    input  logic clk,
    input  logic rst,
`ifdef COUNTER_MONITOR_CLR_EN
    input  logic clr,
`endif
    counter_monitor_if.slave mon
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_TRACK = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    localparam logic [WIDTH-1:0] WRAP_V = WIDTH'(WRAP_VAL);
    localparam logic [3:0]       LOCK_V = 4'(LOCK_N);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] nxt;
    logic [3:0]       run_q;
    logic [3:0]       run_d;
    logic             locked_q;
    logic             mis_q;
    logic             rng_q;
    logic             sticky_q;
    logic [CNT_W-1:0] err_q;
    logic [CNT_W-1:0] wrap_q;

    logic             pred_valid;
    logic             mis_now;
    logic             rng_now;
    logic             wrap_now;
    logic             err_now;
    logic             clr_now;

`ifdef COUNTER_MONITOR_CLR_EN
    assign clr_now = clr;
`else
    assign clr_now = 1'b0;
`endif

    // Predict the next count from the value actually seen, so the monitor resynchronises by itself
    always_comb begin
        nxt = '0;
        if (mon.cnt_en && (mon.cnt_in != WRAP_V)) begin
            nxt = mon.cnt_in + WIDTH'(1);
        end
    end

    // Classify this sample: sequence error (only once a prediction exists), range error, verified wrap
    always_comb begin
        pred_valid = (state_q != ST_IDLE);
        mis_now    = pred_valid && (mon.cnt_in != exp_q);
        rng_now    = (mon.cnt_in > WRAP_V);
        wrap_now   = (state_q == ST_TRACK) && !mis_now && mon.cnt_en && (mon.cnt_in == WRAP_V);
        err_now    = mis_now || rng_now;
    end

    // Lock state machine and the run of consecutive matches needed to regain lock
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_TRACK;
                run_d   = '0;
            end
            ST_TRACK: begin
                if (mis_now) begin
                    state_d = ST_FAULT;
                    run_d   = '0;
                end
            end
            ST_FAULT: begin
                if (mis_now) begin
                    run_d = '0;
                end else if ((run_q + 4'd1) >= LOCK_V) begin
                    state_d = ST_TRACK;
                    run_d   = '0;
                end else begin
                    run_d = run_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                run_d   = '0;
            end
        endcase
    end

    // State, prediction and lock flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            exp_q    <= '0;
            run_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            exp_q    <= nxt;
            run_q    <= run_d;
            locked_q <= (state_d == ST_TRACK);
        end
    end

    // Single-cycle error pulses, raised the cycle after the offending sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mis_q <= 1'b0;
            rng_q <= 1'b0;
        end else begin
            mis_q <= mis_now;
            rng_q <= rng_now;
        end
    end

    // Sticky flag and saturating event counters; a clear beats a coincident event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_q <= 1'b0;
            err_q    <= '0;
            wrap_q   <= '0;
        end else if (clr_now) begin
            sticky_q <= 1'b0;
            err_q    <= '0;
            wrap_q   <= '0;
        end else begin
            if (err_now) begin
                sticky_q <= 1'b1;
                if (!(&err_q)) begin
                    err_q <= err_q + CNT_W'(1);
                end
            end
            if (wrap_now && !(&wrap_q)) begin
                wrap_q <= wrap_q + CNT_W'(1);
            end
        end
    end

    assign mon.exp_val    = exp_q;
    assign mon.locked     = locked_q;
    assign mon.mismatch   = mis_q;
    assign mon.range_err  = rng_q;
    assign mon.err_sticky = sticky_q;
    assign mon.err_cnt    = err_q;
    assign mon.wrap_cnt   = wrap_q;

endmodule
